// File: rtl/jtag_scan_master.sv
// Virtual-JTAG scan initiator: IR update, DR capture/shift/update with a divided TCK.
// Optional IR cache (skip UIR when the IR is unchanged): define JTAG_SCAN_MASTER_IR_CACHE_EN.
module jtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int CLK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  // state | meaning
  // IDLE  | waiting for a command       UIR/CDR/UDR/RTI | one TCK period each
  // SHIFT | DR_WIDTH TCK periods        RESP            | response held until rsp_ready
  typedef enum logic [2:0] {
    S_IDLE, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RESP
  } state_t;

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DR_WIDTH - 1);

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic [DR_WIDTH-1:0] sr_q, sr_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic                tdo_q, tdo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                tck_q, tck_d;
  logic                period_end, tck_rise;
  logic                skip_uir;

`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
  logic [IR_WIDTH-1:0] last_ir_q, last_ir_d;
  logic                last_ir_vld_q, last_ir_vld_d;

  assign skip_uir = last_ir_vld_q && (cmd_ir == last_ir_q);

  always_comb begin
    last_ir_d     = last_ir_q;
    last_ir_vld_d = last_ir_vld_q;
    if (state_q == S_IDLE && cmd_valid) begin
      last_ir_d     = cmd_ir;
      last_ir_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ir_q     <= '0;
      last_ir_vld_q <= 1'b0;
    end else begin
      last_ir_q     <= last_ir_d;
      last_ir_vld_q <= last_ir_vld_d;
    end
  end
`else
  assign skip_uir = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    tdo_d       = tdo_q;
    ir_in_d     = ir_in_q;
    rsp_ir_d    = rsp_ir_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = rsp_valid_q;
    period_end  = (div_q == DIV_LAST);
    tck_rise    = (div_q == DIV_RISE);

    if (state_q != S_IDLE && state_q != S_RESP) begin
      div_d = period_end ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ir_in_d = cmd_ir;
          sr_d    = cmd_data;
          div_d   = '0;
          bit_d   = '0;
          state_d = skip_uir ? S_CDR : S_UIR;
        end
      end
      S_UIR: if (period_end) state_d = S_CDR;
      S_CDR: if (period_end) state_d = S_SHIFT;
      S_SHIFT: begin
        // tdo is taken on the TCK rising cycle, shifted in on the falling boundary
        if (tck_rise) tdo_d = tdo;
        if (period_end) begin
          sr_d = {tdo_q, sr_q[DR_WIDTH-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_UDR;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      S_UDR: begin
        if (tck_rise) rsp_ir_d = ir_out;
        if (period_end) state_d = S_RTI;
      end
      S_RTI: begin
        if (period_end) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = sr_q;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tck_d = (state_d != S_IDLE) && (state_d != S_RESP) && (div_d >= DIV_HIGH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      tdo_q       <= 1'b0;
      ir_in_q     <= '0;
      rsp_ir_q    <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      tck_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      tdo_q       <= tdo_d;
      ir_in_q     <= ir_in_d;
      rsp_ir_q    <= rsp_ir_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      tck_q       <= tck_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_ir         = rsp_ir_q;
  assign tck            = tck_q;
  assign tdi            = (state_q == S_SHIFT) && sr_q[0];
  assign ir_in          = ir_in_q;
  assign vs_uir         = (state_q == S_UIR);
  assign vs_cdr         = (state_q == S_CDR);
  assign vs_sdr         = (state_q == S_SHIFT);
  assign vs_udr         = (state_q == S_UDR);
  assign jtag_state_rti = (state_q == S_RTI);

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: instance 0 at CLK_DIV=2, instance 1 at CLK_DIV=1, checked against a scan-level model.
`timescale 1ns/1ps
module tb_jtag_scan_master;
  localparam int DR = 38;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         cmd_valid, cmd_ready, rsp_valid, rsp_ready, tck, tdi, tdo;
  logic [1:0]         vs_uir, vs_cdr, vs_sdr, vs_udr, rti;
  logic [1:0][1:0]    cmd_ir, rsp_ir, ir_in, ir_out;
  logic [1:0][DR-1:0] cmd_data, rsp_data;

  jtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(2), .CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_ir(cmd_ir[0]), .cmd_data(cmd_data[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_ir(rsp_ir[0]),
    .tck(tck[0]), .tdi(tdi[0]), .tdo(tdo[0]), .ir_in(ir_in[0]), .ir_out(ir_out[0]),
    .vs_uir(vs_uir[0]), .vs_cdr(vs_cdr[0]), .vs_sdr(vs_sdr[0]), .vs_udr(vs_udr[0]),
    .jtag_state_rti(rti[0])
  );

  jtag_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(2), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_ir(cmd_ir[1]), .cmd_data(cmd_data[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_ir(rsp_ir[1]),
    .tck(tck[1]), .tdi(tdi[1]), .tdo(tdo[1]), .ir_in(ir_in[1]), .ir_out(ir_out[1]),
    .vs_uir(vs_uir[1]), .vs_cdr(vs_cdr[1]), .vs_sdr(vs_sdr[1]), .vs_udr(vs_udr[1]),
    .jtag_state_rti(rti[1])
  );

  int total = 0;
  int bad   = 0;

  // slave-side stimulus settings (written by tests only)
  logic [1:0]    loop_m;
  logic [DR-1:0] pat [2];
  logic [1:0]    exp_ir [2];
  int            sdr_mark [2] = '{0, 0};
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
  logic [1:0]    m_ir [2];
  bit            m_vld [2];
`endif

  // monitor observations (written by the monitor only)
  int            sdr_n [2]   = '{0, 0};
  int            ph_n [2]    = '{0, 0};
  int            act_cyc [2] = '{0, 0};
  int            hi_cyc [2]  = '{0, 0};
  int            uir_cyc [2] = '{0, 0};
  int            oh_err [2]  = '{0, 0};
  int            tog_err [2] = '{0, 0};
  int            ir_bad [2]  = '{0, 0};
  logic [2:0]    ph_log [2][2048];
  logic [DR-1:0] tdi_cap [2];
  logic [1:0]    prev_tck = 2'b00;
  logic [1:0]    prev_act = 2'b00;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      tdo[g] = loop_m[g] ? tdi[g] : pat[g][6'((sdr_n[g] - sdr_mark[g]) % DR)];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic [4:0] st;
      logic [2:0] code;
      int k;
      st = {vs_uir[g], vs_cdr[g], vs_sdr[g], vs_udr[g], rti[g]};
      if ($countones(st) > 1 || (st == 5'd0 && tck[g]) || (!vs_sdr[g] && tdi[g])) oh_err[g]++;
      if (st != 5'd0) begin
        act_cyc[g]++;
        if (tck[g]) hi_cyc[g]++;
        if (prev_act[g] && tck[g] == prev_tck[g]) tog_err[g]++;
      end
      if (vs_uir[g]) uir_cyc[g]++;
      if (tck[g] && !prev_tck[g]) begin
        case (st)
          5'b10000: code = 3'd1;
          5'b01000: code = 3'd2;
          5'b00100: code = 3'd3;
          5'b00010: code = 3'd4;
          5'b00001: code = 3'd5;
          default:  code = 3'd7;
        endcase
        if (ph_n[g] < 2048) ph_log[g][ph_n[g]] = code;
        ph_n[g]++;
        if (ir_in[g] !== exp_ir[g]) ir_bad[g]++;
        if (vs_sdr[g]) begin
          k = sdr_n[g] - sdr_mark[g];
          if (k >= 0 && k < DR) tdi_cap[g][k] = tdi[g];
          sdr_n[g]++;
        end
      end
      prev_tck[g] = tck[g];
      prev_act[g] = (st != 5'd0);
    end
  end

  function automatic int cd_of(input int g);
    return (g == 0) ? 2 : 1;
  endfunction

  function automatic logic [DR-1:0] rnd_dr();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DR-1:0];
  endfunction

  // phase expected at TCK rise number i of a command
  function automatic logic [2:0] exp_code(input int i, input bit hit);
    int j;
    j = hit ? i + 1 : i;
    if (j == 0) return 3'd1;
    if (j == 1) return 3'd2;
    if (j < 2 + DR) return 3'd3;
    if (j == 2 + DR) return 3'd4;
    return 3'd5;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
`endif
  endtask

  task automatic do_cmd(input int g, input logic [1:0] ir, input logic [DR-1:0] data, input bit lb,
                        input logic [DR-1:0] p, input logic [1:0] iro, input int hold);
    int cd, phases, exp_lat, n, a0, h0, u0, o0, t0, i0, pm, nph, miss;
    bit hit, stable;
    logic [DR-1:0] exp_data, d0;
    cd  = cd_of(g);
    hit = 1'b0;
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
    hit = m_vld[g] && (m_ir[g] == ir);
    m_vld[g] = 1'b1;
    m_ir[g]  = ir;
`endif
    phases   = DR + 4 - (hit ? 1 : 0);
    exp_lat  = phases * 2 * cd;
    exp_data = lb ? data : p;

    @(negedge clk);
    total++;
    if (cmd_ready[g] !== 1'b1) begin
      bad++; $display("FAIL ready_idle g=%0d got=%b want=1", g, cmd_ready[g]);
    end
    loop_m[g] = lb; pat[g] = p; exp_ir[g] = ir; ir_out[g] = iro; sdr_mark[g] = sdr_n[g];
    a0 = act_cyc[g]; h0 = hi_cyc[g]; u0 = uir_cyc[g]; o0 = oh_err[g]; t0 = tog_err[g];
    i0 = ir_bad[g]; pm = ph_n[g];
    cmd_valid[g] = 1'b1; cmd_ir[g] = ir; cmd_data[g] = data;
    @(posedge clk); #1;
    cmd_valid[g] = 1'b0; cmd_data[g] = ~data;
    total++;
    if (ir_in[g] !== ir) begin
      bad++; $display("FAIL ir_load g=%0d got=%b want=%b", g, ir_in[g], ir);
    end

    n = 0;
    while (rsp_valid[g] !== 1'b1 && n < exp_lat + 20) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n !== exp_lat) begin
      bad++; $display("FAIL latency g=%0d got=%0d want=%0d", g, n, exp_lat);
    end
    total++;
    if (rsp_data[g] !== exp_data) begin
      bad++; $display("FAIL rsp_data g=%0d got=%h want=%h", g, rsp_data[g], exp_data);
    end
    total++;
    if (rsp_ir[g] !== iro) begin
      bad++; $display("FAIL rsp_ir g=%0d got=%b want=%b", g, rsp_ir[g], iro);
    end
    total++;
    if (tdi_cap[g] !== data) begin
      bad++; $display("FAIL tdi_stream g=%0d got=%h want=%h", g, tdi_cap[g], data);
    end
    total++;
    if (act_cyc[g] - a0 !== exp_lat || hi_cyc[g] - h0 !== exp_lat / 2) begin
      bad++; $display("FAIL tck_duty g=%0d active=%0d high=%0d want %0d/%0d", g,
                      act_cyc[g] - a0, hi_cyc[g] - h0, exp_lat, exp_lat / 2);
    end
    total++;
    if (uir_cyc[g] - u0 !== (hit ? 0 : 2 * cd)) begin
      bad++; $display("FAIL uir_len g=%0d got=%0d want=%0d", g, uir_cyc[g] - u0, hit ? 0 : 2 * cd);
    end
    total++;
    if (oh_err[g] - o0 !== 0 || ir_bad[g] - i0 !== 0) begin
      bad++; $display("FAIL onehot_ir g=%0d strobe_errs=%0d ir_errs=%0d want 0/0", g,
                      oh_err[g] - o0, ir_bad[g] - i0);
    end
    if (g == 1) begin
      total++;
      if (tog_err[g] - t0 !== 0) begin
        bad++; $display("FAIL tck_toggle g=%0d stalls=%0d want=0", g, tog_err[g] - t0);
      end
    end
    nph  = ph_n[g] - pm;
    miss = 0;
    for (int i = 0; i < nph && i < phases; i++) begin
      if (ph_log[g][pm + i] !== exp_code(i, hit)) miss++;
    end
    total++;
    if (nph !== phases || miss !== 0) begin
      bad++; $display("FAIL phase_seq g=%0d periods=%0d wrong=%0d want periods=%0d", g, nph, miss, phases);
    end

    d0 = rsp_data[g];
    if (hold > 0) begin
      stable = 1'b1;
      cmd_valid[g] = 1'b1; cmd_ir[g] = ~ir; cmd_data[g] = ~data;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (rsp_valid[g] !== 1'b1 || rsp_data[g] !== d0 || cmd_ready[g] !== 1'b0 ||
            vs_uir[g] !== 1'b0 || vs_cdr[g] !== 1'b0 || ir_in[g] !== ir) stable = 1'b0;
      end
      cmd_valid[g] = 1'b0;
      total++;
      if (stable !== 1'b1) begin
        bad++; $display("FAIL backpressure_hold g=%0d stable=%b want=1", g, stable);
      end
    end
    total++;
    if (cmd_ready[g] !== 1'b0) begin
      bad++; $display("FAIL ready_in_resp g=%0d got=%b want=0", g, cmd_ready[g]);
    end
    rsp_ready[g] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[g] = 1'b0;
    total++;
    if (rsp_valid[g] !== 1'b0 || cmd_ready[g] !== 1'b1) begin
      bad++; $display("FAIL handshake g=%0d rsp_valid=%b cmd_ready=%b want 0/1", g, rsp_valid[g], cmd_ready[g]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({cmd_ready[g], rsp_valid[g], tck[g], tdi[g], vs_uir[g], vs_cdr[g], vs_sdr[g], vs_udr[g], rti[g]}
          !== 9'b1_0000_0000) begin
        bad++; $display("FAIL reset_ctl g=%0d got=%b want=100000000", g,
          {cmd_ready[g], rsp_valid[g], tck[g], tdi[g], vs_uir[g], vs_cdr[g], vs_sdr[g], vs_udr[g], rti[g]});
      end
      total++;
      if (ir_in[g] !== 2'b00 || rsp_ir[g] !== 2'b00 || rsp_data[g] !== '0) begin
        bad++; $display("FAIL reset_data g=%0d ir_in=%b rsp_ir=%b rsp_data=%h want zeros", g,
                        ir_in[g], rsp_ir[g], rsp_data[g]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_loopback();
    do_cmd(0, 2'b01, 38'h2A_5A5A_5A5A, 1'b1, '0, 2'b01, 0);
    do_cmd(0, 2'($urandom_range(0, 3)), rnd_dr(), 1'b1, '0, 2'($urandom_range(0, 3)), 0);
  endtask

  task automatic test_tdo_ones_div1();
    do_cmd(1, 2'b10, '0, 1'b0, {DR{1'b1}}, 2'b01, 0);
    do_cmd(1, 2'($urandom_range(0, 3)), rnd_dr(), 1'b0, rnd_dr(), 2'($urandom_range(0, 3)), 0);
  endtask

  task automatic test_strobes();
    do_cmd(0, 2'b00, rnd_dr(), 1'b1, '0, 2'b10, 0);
  endtask

  task automatic test_back_pressure();
    do_cmd(0, 2'b01, rnd_dr(), 1'b0, rnd_dr(), 2'b11, 10);
    do_cmd(1, 2'b11, rnd_dr(), 1'b1, '0, 2'b10, 10);
  endtask

  task automatic test_reset_mid_shift();
    int n;
    bit quiet;
    @(negedge clk);
    loop_m[0] = 1'b1; exp_ir[0] = 2'b10; ir_out[0] = 2'b01; sdr_mark[0] = sdr_n[0];
    cmd_valid[0] = 1'b1; cmd_ir[0] = 2'b10; cmd_data[0] = rnd_dr();
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    n = 0;
    while (sdr_n[0] - sdr_mark[0] < 21 && n < 1000) begin
      @(negedge clk); n++;
    end
    total++;
    if (sdr_n[0] - sdr_mark[0] !== 21) begin
      bad++; $display("FAIL reach_bit20 got=%0d want=21", sdr_n[0] - sdr_mark[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      total++;
      if ({cmd_ready[g], rsp_valid[g], tck[g], tdi[g], vs_uir[g], vs_cdr[g], vs_sdr[g], vs_udr[g], rti[g]}
          !== 9'b1_0000_0000) begin
        bad++; $display("FAIL midreset_ctl g=%0d got=%b want=100000000", g,
          {cmd_ready[g], rsp_valid[g], tck[g], tdi[g], vs_uir[g], vs_cdr[g], vs_sdr[g], vs_udr[g], rti[g]});
      end
      total++;
      if (ir_in[g] !== 2'b00 || rsp_ir[g] !== 2'b00 || rsp_data[g] !== '0) begin
        bad++; $display("FAIL midreset_data g=%0d ir_in=%b rsp_ir=%b rsp_data=%h want zeros", g,
                        ir_in[g], rsp_ir[g], rsp_data[g]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
    m_vld[0] = 1'b0;
    m_vld[1] = 1'b0;
`endif
    quiet = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || tck[0] !== 1'b0) quiet = 1'b0;
    end
    total++;
    if (quiet !== 1'b1) begin
      bad++; $display("FAIL midreset_quiet quiet=%b want=1", quiet);
    end
    do_cmd(0, 2'b10, rnd_dr(), 1'b1, '0, 2'b01, 0);
  endtask

  task automatic test_ir_cache();
    pulse_reset();
    do_cmd(0, 2'b11, rnd_dr(), 1'b1, '0, 2'b10, 0);
    do_cmd(0, 2'b11, rnd_dr(), 1'b0, rnd_dr(), 2'b01, 0);
    do_cmd(0, 2'b00, rnd_dr(), 1'b1, '0, 2'b11, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_cmd(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rnd_dr(), 1'($urandom_range(0, 1)),
             rnd_dr(), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    cmd_valid = '0; rsp_ready = '0; cmd_ir = '0; cmd_data = '0; ir_out = '0; loop_m = '0;
    pat[0] = '0; pat[1] = '0; exp_ir[0] = '0; exp_ir[1] = '0;
`ifdef JTAG_SCAN_MASTER_IR_CACHE_EN
    m_ir[0] = '0; m_ir[1] = '0; m_vld[0] = 1'b0; m_vld[1] = 1'b0;
`endif
    test_reset();
    test_loopback();
    test_tdo_ones_div1();
    test_strobes();
    test_back_pressure();
    test_reset_mid_shift();
    test_ir_cache();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
